// File: rtl/ddr_icap_gearbox.sv
// DDR-to-ICAP gearbox: buffers 256-bit DMA read beats and serialises each into eight 32-bit ICAP words.
// Optional build macro ICAP_BITSWAP_EN bit-reverses every byte of o_icap_data.
module ddr_icap_gearbox #(
    parameter int DEPTH       = 4,
    parameter int AFULL_SLACK = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [255:0] i_ddr_data,
    input  logic         i_ddr_data_valid,
    input  logic         i_abort,
    input  logic         i_icap_ready,
    output logic [31:0]  o_icap_data,
    output logic         o_icap_csib,
    output logic         o_icap_rdwrb,
    output logic         o_config_buff_full,
    output logic         o_overflow,
    output logic [31:0]  o_word_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_SLACK);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [255:0]   shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    word_cnt_q, word_cnt_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;

    logic           has_data;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           xfer;
    logic [31:0]    word;

    assign has_data  = (count_q != '0);
    assign fifo_full = (count_q == FULL_CNT);
    // Abort discards any beat arriving in the same cycle.
    assign push      = i_ddr_data_valid && !fifo_full && !i_abort;
    assign xfer      = (state_q == STREAM) && i_icap_ready;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        shift_d    = shift_q;
        idx_d      = idx_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    word_cnt_d = word_cnt_q + 32'd1;
                    idx_d      = idx_q + 3'd1;
                    shift_d    = {shift_q[223:0], 32'h0};
                    // Last word: chain straight into the next beat so csib never rises.
                    if (idx_q == 3'd7) begin
                        if (has_data) begin
                            pop     = 1'b1;
                            shift_d = mem_q[rd_ptr_q];
                            idx_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d    = IDLE;
            pop        = 1'b0;
            idx_d      = 3'd0;
            word_cnt_d = 32'd0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (i_abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d = (count_q >= AFULL_CNT);
        ovf_d  = ovf_q || (i_ddr_data_valid && fifo_full);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= 3'd0;
            word_cnt_q <= 32'd0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            word_cnt_q <= word_cnt_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    // Payload storage carries no reset; the output is gated by state instead.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        if (push) mem_q[wr_ptr_q] <= i_ddr_data;
    end

    assign word = (state_q == STREAM) ? shift_q[255:224] : 32'h0;

`ifdef ICAP_BITSWAP_EN
    function automatic logic [31:0] bitswap_bytes(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*k+j] = w[8*k+7-j];
            end
        end
        return r;
    endfunction
    assign o_icap_data = bitswap_bytes(word);
`else
    assign o_icap_data = word;
`endif

    assign o_icap_csib        = (state_q != STREAM);
    assign o_icap_rdwrb       = 1'b0;
    assign o_config_buff_full = full_q;
    assign o_overflow         = ovf_q;
    assign o_word_cnt         = word_cnt_q;

endmodule

// File: tb/tb_ddr_icap_gearbox.sv
// Scoreboard bench for ddr_icap_gearbox: queue-based reference model plus an independent word monitor.
module tb_ddr_icap_gearbox;

    localparam int DEPTH       = 4;
    localparam int AFULL_SLACK = 2;
    localparam int THR         = DEPTH - AFULL_SLACK;

    logic         clk;
    logic         rst_n;
    logic [255:0] ddr_data;
    logic         ddr_valid;
    logic         abort;
    logic         icap_ready;
    logic [31:0]  icap_data;
    logic         icap_csib;
    logic         icap_rdwrb;
    logic         buff_full;
    logic         overflow;
    logic [31:0]  word_cnt;

    int checks   = 0;
    int failures = 0;

    ddr_icap_gearbox #(.DEPTH(DEPTH), .AFULL_SLACK(AFULL_SLACK)) dut (
        .i_clk              (clk),
        .i_rst              (rst_n),
        .i_ddr_data         (ddr_data),
        .i_ddr_data_valid   (ddr_valid),
        .i_abort            (abort),
        .i_icap_ready       (icap_ready),
        .o_icap_data        (icap_data),
        .o_icap_csib        (icap_csib),
        .o_icap_rdwrb       (icap_rdwrb),
        .o_config_buff_full (buff_full),
        .o_overflow         (overflow),
        .o_word_cnt         (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending beats, remaining words of the beat on the wire, status flags.
    logic [255:0] mq[$];
    logic [31:0]  mw[$];
    logic         m_full;
    logic         m_ovf;
    logic [31:0]  m_cnt;
    logic [31:0]  sb[$];

    function automatic logic [31:0] exp_out(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_BITSWAP_EN
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
                r[8*k+j] = w[8*k+7-j];
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mw.delete();
        sb.delete();
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 32'd0;
    endtask

    task automatic check_outputs();
        check("csib",     {31'd0, icap_csib},  {31'd0, (mw.size() == 0)});
        check("data",     icap_data,           (mw.size() > 0) ? exp_out(mw[0]) : 32'h0);
        check("rdwrb",    {31'd0, icap_rdwrb}, 32'd0);
        check("full",     {31'd0, buff_full},  {31'd0, m_full});
        check("overflow", {31'd0, overflow},   {31'd0, m_ovf});
        check("word_cnt", word_cnt,            m_cnt);
    endtask

    // Checks the current cycle against the model, then advances the model by one clock.
    task automatic step_model();
        int n0;
        logic streaming;
        logic [255:0] beat;
        check_outputs();
        n0 = mq.size();
        streaming = (mw.size() > 0);
        if (streaming && icap_ready) sb.push_back(exp_out(mw[0]));
        if (ddr_valid && n0 == DEPTH) m_ovf = 1'b1;
        m_full = (n0 >= THR);
        if (abort) begin
            mq.delete();
            mw.delete();
            m_cnt = 32'd0;
            return;
        end
        if (streaming && icap_ready) begin
            void'(mw.pop_front());
            m_cnt = m_cnt + 32'd1;
        end
        if (mw.size() == 0 && n0 > 0) begin
            beat = mq.pop_front();
            for (int k = 0; k < 8; k++) mw.push_back(beat[255-32*k -: 32]);
        end
        if (ddr_valid && n0 < DEPTH) mq.push_back(ddr_data);
    endtask

    task automatic cycle(input logic v, input logic [255:0] d, input logic ab, input logic r);
        @(posedge clk);
        #1;
        ddr_valid  = v;
        ddr_data   = d;
        abort      = ab;
        icap_ready = r;
        @(negedge clk);
        step_model();
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // Monitor: every accepted ICAP word must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && !icap_csib && icap_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word_unexpected at %0t: got=%h expected=none", $time, icap_data);
                end else begin
                    check("word", icap_data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [255:0] beat;
        rst_n      = 1'b0;
        ddr_valid  = 1'b0;
        ddr_data   = '0;
        abort      = 1'b0;
        icap_ready = 1'b0;
        model_reset();
        #12;
        check_outputs();
        #10;
        rst_n = 1'b1;

        // Single incrementing beat, ready held high.
        beat = {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        cycle(1'b1, beat, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("cnt_after_beat", word_cnt, 32'd8);

        // Byte-ordering probe beat.
        beat = {32'h01020304, 32'h80C0A0E0, 32'hFF00F00F, 32'h12345678,
                32'hDEADBEEF, 32'h00000001, 32'h80000000, 32'hA5A55A5A};
        cycle(1'b1, beat, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Six back-to-back beats with ready low: fill, almost-full, overflow; then drain.
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 50; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Ready toggling during a beat.
        cycle(1'b1, rand_beat(), 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, '0, 1'b0, (i % 2) == 0);

        // Abort while word 3 of the second of three queued beats is on the wire.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (mw.size() == 5 && mq.size() == 1) break;
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        check("abort_point", mw.size(), 32'd5);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic with occasional aborts.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 1) == 1), rand_beat(), ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7));

        // Asynchronous reset mid-stream.
        cycle(1'b1, rand_beat(), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        #2;
        ddr_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Final traffic and drain; every expected word must have been consumed.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
